// File: rtl/popcount_seq15.sv
// popcount_seq15: sequential ones counter for a 15-bit word.
// One shared full-adder cell consumes three bits per clock from a shift
// register; five groups yield the 4-bit population count. A small
// IDLE/RUN/DONE FSM provides the start/busy/done handshake.
module popcount_seq15 (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [14:0] din,
   output logic        busy,
   output logic        done,
   output logic [3:0]  count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Index of the last group; the edge that consumes it also registers the result.
   localparam logic [2:0] LAST_STEP = 3'd4;

   state_t      state_reg, state_next;
   logic [14:0] sh_reg, sh_next;
   logic [3:0]  acc_reg, acc_next;
   logic [2:0]  step_reg, step_next;
   logic [3:0]  count_reg, count_next;

   logic        fa_sum;
   logic        fa_carry;
   logic [1:0]  fa_inc;

   // Shared full-adder cell on the three lowest bits of the shift register.
   always_comb begin
      fa_sum   = sh_reg[0] ^ sh_reg[1] ^ sh_reg[2];
      fa_carry = (sh_reg[0] & sh_reg[1]) | (sh_reg[0] & sh_reg[2]) | (sh_reg[1] & sh_reg[2]);
      fa_inc   = {fa_carry, fa_sum};
   end

   // State and datapath registers; reset clears everything, including the last result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         sh_reg    <= '0;
         acc_reg   <= '0;
         step_reg  <= '0;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         sh_reg    <= sh_next;
         acc_reg   <= acc_next;
         step_reg  <= step_next;
         count_reg <= count_next;
      end
   end

   // Next-state and datapath sequencing; everything holds unless a state says otherwise.
   always_comb begin
      state_next = state_reg;
      sh_next    = sh_reg;
      acc_next   = acc_reg;
      step_next  = step_reg;
      count_next = count_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               sh_next    = din;
               acc_next   = '0;
               step_next  = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            if (step_reg > LAST_STEP) begin
               // Corrupted group counter: abandon the operation without a result.
               step_next  = '0;
               state_next = IDLE;
            end else begin
               acc_next  = acc_reg + {2'b00, fa_inc};
               sh_next   = sh_reg >> 3;
               step_next = step_reg + 3'd1;
               if (step_reg == LAST_STEP) begin
                  // Parking the counter at 0 keeps it inside the legal 0..4 range.
                  count_next = acc_reg + {2'b00, fa_inc};
                  step_next  = '0;
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Handshake outputs decode directly from the state register.
   always_comb begin
      busy  = (state_reg != IDLE);
      done  = (state_reg == DONE);
      count = count_reg;
   end

endmodule

// File: tb/tb_popcount_seq15.sv
// Testbench for popcount_seq15: table-driven single operations, a scoreboard
// that checks count and latency on every done pulse, and hand-written
// sequences for back-to-back, start/din isolation and reset abort.
module tb_popcount_seq15;

   logic        clk;
   logic        rst;
   logic        start;
   logic [14:0] din;
   logic        busy;
   logic        done;
   logic [3:0]  count;

   popcount_seq15 dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .din   (din),
      .busy  (busy),
      .done  (done),
      .count (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [14:0] din;
      logic [3:0]  cnt;
   } vec_t;

   typedef struct {
      int cnt;
      int cyc;
   } sb_t;

   sb_t  sb[$];
   int   checks    = 0;
   int   passes    = 0;
   int   cyc       = 0;
   int   done_seen = 0;
   int   ops_exp   = 0;
   int   exp_count = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: push expected result at each acceptance edge, pop on done.
   initial begin
      sb_t e;
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst && start && !busy) begin
            e.cnt = exp_count;
            e.cyc = cyc;
            sb.push_back(e);
         end
         #1;
         if (done) begin
            done_seen++;
            if (sb.size() == 0) begin
               chk("spurious_done", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("count", int'(count), e.cnt);
               chk("latency", cyc - e.cyc, 5);
               $display("op done: count=%0d expected=%0d latency=%0d", count, e.cnt, cyc - e.cyc);
            end
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 20) begin
         tick();
         n++;
      end
      if (busy) chk("idle_timeout", 1, 0);
   endtask

   // One full operation with timing checks; din is scrambled after acceptance.
   task automatic run_op(input logic [14:0] d, input logic [3:0] c);
      wait_idle();
      din       = d;
      exp_count = int'(c);
      start     = 1'b1;
      tick();                              // T0
      start = 1'b0;
      din   = ~d;
      chk("busy_after_accept", int'(busy), 1);
      repeat (4) tick();                   // T4
      chk("done_early", int'(done), 0);
      tick();                              // T5
      chk("done_at_t5", int'(done), 1);
      chk("busy_at_t5", int'(busy), 1);
      tick();                              // T6
      chk("done_after_t6", int'(done), 0);
      chk("busy_after_t6", int'(busy), 0);
      chk("count_hold", int'(count), int'(c));
      ops_exp++;
   endtask

   initial begin
      vec_t vecs[9];
      int   snap;

      vecs[0] = '{15'h0000, 4'd0};
      vecs[1] = '{15'h7FFF, 4'd15};
      vecs[2] = '{15'h5555, 4'd8};
      vecs[3] = '{15'h0001, 4'd1};
      vecs[4] = '{15'h2AAA, 4'd7};
      vecs[5] = '{15'h0007, 4'd3};
      vecs[6] = '{15'h00F0, 4'd4};
      vecs[7] = '{15'h4001, 4'd2};
      vecs[8] = '{15'h1248, 4'd4};

      rst   = 1'b1;
      start = 1'b0;
      din   = '0;
      #2;
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_count", int'(count), 0);
      repeat (2) tick();
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].din, vecs[i].cnt);
      end

      // Back to back with start held high: accepts at T0 and T7.
      wait_idle();
      din       = 15'h5555;
      exp_count = 8;
      start     = 1'b1;
      tick();                              // T0
      din       = 15'h0001;
      exp_count = 1;
      repeat (5) tick();                   // T5
      chk("b2b_done1", int'(done), 1);
      tick();                              // T6
      chk("b2b_busy_t6", int'(busy), 0);
      tick();                              // T7
      chk("b2b_busy_t7", int'(busy), 1);
      start = 1'b0;
      repeat (4) tick();                   // T11
      chk("b2b_done_t11", int'(done), 0);
      tick();                              // T12
      chk("b2b_done_t12", int'(done), 1);
      tick();
      ops_exp += 2;

      // Start and din isolation: extra start during RUN is ignored.
      wait_idle();
      din       = 15'h0007;
      exp_count = 3;
      start     = 1'b1;
      tick();                              // T0
      start = 1'b0;
      din   = 15'h7FFF;
      exp_count = 15;
      repeat (2) tick();
      start = 1'b1;
      tick();                              // T3
      start = 1'b0;
      repeat (2) tick();                   // T5
      chk("iso_done", int'(done), 1);
      chk("iso_count", int'(count), 3);
      tick();                              // T6
      snap = done_seen;
      repeat (8) tick();
      chk("iso_no_extra_op", done_seen, snap);
      chk("iso_idle", int'(busy), 0);
      ops_exp++;

      // Reset abort between T3 and T4.
      din       = 15'h7FFF;
      exp_count = 15;
      start     = 1'b1;
      tick();                              // T0
      start = 1'b0;
      repeat (3) tick();                   // T3
      #2;
      rst = 1'b1;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_count", int'(count), 0);
      sb.delete();
      tick();
      rst = 1'b0;
      snap = done_seen;
      run_op(15'h00F0, 4'd4);
      chk("abort_one_done_after", done_seen - snap, 1);

      repeat (3) tick();
      chk("sb_empty", sb.size(), 0);
      chk("done_total", done_seen, ops_exp);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
